osnt_packet_cutter_mp: RTL and testbench
========================================

Name: osnt_packet_cutter_mp

Overview:
- Next-generation packet cutter for the OSNT monitoring path. It sits between the RX queues and the timestamp/DMA path.
- Truncates each packet to a byte-granular snap length. The snap length is per source port and parametrised in data width and port count.
- Rewrites the TUSER length field and keeps per-port packet statistics.
- Fully AXI4-Stream compliant: one output register stage, correct backpressure, and the remainder of a cut packet is discarded.

Parameters:
- C_AXIS_DATA_WIDTH, 256, TDATA width in bits; power of two, 64..1024.
- C_AXIS_TUSER_WIDTH, 128, TUSER width; [15:0] = byte length, [23:16] = one-hot source port.
- NUM_PORTS, 4, number of source ports with independent config (1..8).
- LEN_WIDTH, 16, width of byte counters and snap-length fields.
- MIN_SNAP, 64, smallest snap length honoured; smaller programmed values are clamped up to this.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- axi_aclk  in  1  clock.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  input metadata.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  same widths as input  output stream.
- m_axis_tready  in  1  output ready.
- cut_en  in  NUM_PORTS  per-port cut enable.
- snap_len  in  NUM_PORTS*LEN_WIDTH  per-port snap length in bytes.
- stats_clr  in  1  one-cycle pulse; clears all counters.
- pkt_in_cnt  out  NUM_PORTS*CNT_WIDTH  packets accepted, per port.
- pkt_cut_cnt  out  NUM_PORTS*CNT_WIDTH  packets truncated, per port.
- pkt_out_cnt  out  CNT_WIDTH  packets emitted.

Behaviour:
- **Reset values:** m_axis_tvalid=0; all m_axis data/keep/user/last outputs 0; s_axis_tready=0 during reset and 1 in the first cycle after it; all counters 0; FSM in IDLE.
- **Output stage:** single register. s_axis_tready = !m_axis_tvalid | m_axis_tready, except in DROP where it is 1. Latency is 1 cycle. Output holds stable while tvalid=1 and tready=0.
- **SOP capture:** on the first beat of a packet, the source port is taken from tuser[23:16]. If zero or multi-hot, the lowest set bit is used; if none is set, port 0 is used. That port's cut_en and snap_len (clamped to ≥MIN_SNAP) are latched. Config changes after this point do not affect the current packet.
- **FSM states:**
  - IDLE: waiting for the first beat.
  - PASS: forwarding beats. byte_cnt accumulates whole beats (W = C_AXIS_DATA_WIDTH/8 bytes each).
  - DROP: accepting and discarding beats until tlast.
- **Cut point:** on a beat where byte_cnt+W ≥ snap and the input is not already ending within snap:
  - emit the beat with tkeep = low (snap−byte_cnt) bits set and tlast=1;
  - if s_axis_tlast=0, go to DROP; otherwise go to IDLE.
- **Packets not cut:** if the packet ends at or before snap (including exactly equal to snap), or cut is disabled, it is forwarded unmodified and is not counted as cut.
- **TUSER rewrite:** tuser[15:0] on the first output beat is set to min(orig_len, snap). All other TUSER bits pass through.
- **Header/cut in the same beat:** if the cut point falls in the first beat (snap ≤ W), that beat carries both the rewritten TUSER and tlast.
- **Counters:**
  - pkt_in increments on an accepted input tlast, for the latched port.
  - pkt_cut increments on the cut beat when input tlast is not present on that beat.
  - pkt_out increments on an output tlast handshake.
  - Counters wrap modulo 2^CNT_WIDTH.
  - If stats_clr coincides with an increment, clear wins and the result is 0.
- **Reset mid-packet:** the FSM returns to IDLE. The next accepted beat is treated as SOP. A partial packet is never completed.

Decomposition:
- Package osnt_cutter_pkg holds:
  - the FSM state enum (IDLE, PASS, DROP);
  - TUSER field offsets (LEN_LSB=0, LEN_MSB=15, SRC_LSB=16, SRC_MSB=23);
  - a keep_mask(n) function returning n low bits set.
- One sub-module, osnt_cutter_stats, holds the counter bank and the clear logic.

Test Plan (C_AXIS_DATA_WIDTH=256, W=32, NUM_PORTS=4):
1. Port 0, cut_en=1, snap=64, 100-byte packet (4 beats) → 2 output beats; beat 2 has tkeep=0xFFFFFFFF and tlast=1; tuser[15:0]=64; beats 3–4 are consumed with tready=1; pkt_cut[0]=1.
2. Port 1, snap=70, 100-byte packet → 3 output beats; beat 3 has tkeep=0x0000003F; tuser len=70.
3. snap=64 with a 60-byte packet, and again with a 64-byte packet → both forwarded unchanged; pkt_cut stays 0; pkt_out=2.
4. cut_en=0 on port 2, 1500-byte packet from port 2 → all 47 beats forwarded; tuser len=1500. snap=10 on port 3 → clamped to 64.
5. Random m_axis_tready (50%), 200 mixed packets → output matches a reference-model byte stream; no beat is lost or duplicated while tready is low.
6. stats_clr asserted in the same cycle as an output tlast → pkt_out=0 afterwards. axi_reset asserted mid-packet → next packet is output intact.

Source files
------------

// File: rtl/osnt_cutter_pkg.sv
// Shared types and helpers for the OSNT packet cutter: FSM states, TUSER field
// layout and the byte-enable mask builder.
package osnt_cutter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } cut_state_e;

  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned LEN_MSB  = 15;
  localparam int unsigned SRC_LSB  = 16;
  localparam int unsigned SRC_MSB  = 23;
  localparam int unsigned KEEP_MAX = 128;

  // n low bits set; callers truncate to their own tkeep width
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/osnt_cutter_stats.sv
// Per-port accepted/cut packet counters and a global emitted-packet counter.
// A clear pulse overrides any increment in the same cycle.
module osnt_cutter_stats #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PORT_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_inc,
  input  logic                           cut_inc,
  input  logic [PORT_W-1:0]              port,
  input  logic                           out_inc,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_in_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cut_cnt,
  output logic [CNT_WIDTH-1:0]           pkt_out_cnt
);

  logic [NUM_PORTS*CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [NUM_PORTS*CNT_WIDTH-1:0] cut_cnt_q, cut_cnt_d;
  logic [CNT_WIDTH-1:0]           out_cnt_q, out_cnt_d;

  always_comb begin
    in_cnt_d  = in_cnt_q;
    cut_cnt_d = cut_cnt_q;
    out_cnt_d = out_cnt_q;
    if (in_inc)
      in_cnt_d[32'(port)*CNT_WIDTH +: CNT_WIDTH] =
        in_cnt_q[32'(port)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    if (cut_inc)
      cut_cnt_d[32'(port)*CNT_WIDTH +: CNT_WIDTH] =
        cut_cnt_q[32'(port)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    if (out_inc)
      out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
    if (clr) begin
      in_cnt_d  = '0;
      cut_cnt_d = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q  <= '0;
      cut_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      cut_cnt_q <= cut_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign pkt_in_cnt  = in_cnt_q;
  assign pkt_cut_cnt = cut_cnt_q;
  assign pkt_out_cnt = out_cnt_q;

endmodule

// File: rtl/osnt_packet_cutter_mp.sv
// AXI4-Stream packet cutter: truncates each packet to a per-source-port snap
// length, rewrites the TUSER length and discards the tail of cut packets.
module osnt_packet_cutter_mp
  import osnt_cutter_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned LEN_WIDTH          = 16,
  parameter int unsigned MIN_SNAP           = 64,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                             axi_aclk,
  input  logic                             axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  input  logic [NUM_PORTS-1:0]             cut_en,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]   snap_len,
  input  logic                             stats_clr,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   pkt_in_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   pkt_cut_cnt,
  output logic [CNT_WIDTH-1:0]             pkt_out_cnt
);

  localparam int unsigned W        = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BCW      = LEN_WIDTH + 1;
  localparam int unsigned PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned TU_LEN_W = LEN_MSB - LEN_LSB + 1;

  cut_state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]      byte_cnt_q, byte_cnt_d;
  logic                      cut_en_q, cut_en_d;
  logic [LEN_WIDTH-1:0]      snap_q, snap_d;
  logic [PORT_W-1:0]         port_q, port_d;
  logic [C_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [W-1:0]                  tkeep_q, tkeep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;

  logic                 s_ready_c, accept_c, fwd_c, is_sop_c, cut_c;
  logic [PORT_W-1:0]    sop_port_c, eff_port_c;
  logic [LEN_WIDTH-1:0] live_snap_c, eff_snap_c, eff_cnt_c, orig_len_c;
  logic                 eff_en_c;
  logic [BCW-1:0]       beat_bytes_c;
  logic                 ends_in_c, reach_c;

  // DROP swallows the tail regardless of the output register
  assign s_ready_c     = !axi_reset && (state_q == DROP || !tvalid_q || m_axis_tready);
  assign s_axis_tready = s_ready_c;
  assign accept_c      = s_axis_tvalid && s_ready_c;
  assign fwd_c         = accept_c && (state_q != DROP);
  assign is_sop_c      = (state_q == IDLE);

  // Lowest set source bit wins; none set selects port 0
  always_comb begin
    sop_port_c = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--)
      if (s_axis_tuser[SRC_LSB + i]) sop_port_c = PORT_W'(i);
    live_snap_c = snap_len[32'(sop_port_c)*LEN_WIDTH +: LEN_WIDTH];
    if (live_snap_c < LEN_WIDTH'(MIN_SNAP)) live_snap_c = LEN_WIDTH'(MIN_SNAP);
  end

  always_comb begin
    eff_port_c = is_sop_c ? sop_port_c         : port_q;
    eff_en_c   = is_sop_c ? cut_en[sop_port_c] : cut_en_q;
    eff_snap_c = is_sop_c ? live_snap_c        : snap_q;
    eff_cnt_c  = is_sop_c ? '0                 : byte_cnt_q;
    orig_len_c = LEN_WIDTH'(s_axis_tuser[LEN_MSB:LEN_LSB]);
    beat_bytes_c = '0;
    for (int i = 0; i < int'(W); i++) beat_bytes_c = beat_bytes_c + BCW'(s_axis_tkeep[i]);
    ends_in_c = s_axis_tlast && (({1'b0, eff_cnt_c} + beat_bytes_c) <= {1'b0, eff_snap_c});
    reach_c   = ({1'b0, eff_cnt_c} + BCW'(W)) >= {1'b0, eff_snap_c};
    cut_c     = eff_en_c && reach_c && !ends_in_c;
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cut_en_d   = cut_en_q;
    snap_d     = snap_q;
    port_d     = port_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (fwd_c) begin
      tvalid_d = 1'b1;
      tdata_d  = s_axis_tdata;
      tkeep_d  = cut_c ? W'(keep_mask(32'(eff_snap_c - eff_cnt_c))) : s_axis_tkeep;
      tlast_d  = cut_c || s_axis_tlast;
      tuser_d  = s_axis_tuser;
      if (is_sop_c && eff_en_c)
        tuser_d[LEN_MSB:LEN_LSB] = TU_LEN_W'((orig_len_c < eff_snap_c) ? orig_len_c : eff_snap_c);
      byte_cnt_d = eff_cnt_c + LEN_WIDTH'(W);
      if (is_sop_c) begin
        cut_en_d = eff_en_c;
        snap_d   = eff_snap_c;
        port_d   = eff_port_c;
      end
      if (s_axis_tlast)  state_d = IDLE;
      else if (cut_c)    state_d = DROP;
      else               state_d = PASS;
    end else if (accept_c && s_axis_tlast) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      cut_en_q   <= 1'b0;
      snap_q     <= '0;
      port_q     <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cut_en_q   <= cut_en_d;
      snap_q     <= snap_d;
      port_q     <= port_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  osnt_cutter_stats #(
    .NUM_PORTS (NUM_PORTS),
    .CNT_WIDTH (CNT_WIDTH),
    .PORT_W    (PORT_W)
  ) u_stats (
    .clk         (axi_aclk),
    .rst         (axi_reset),
    .clr         (stats_clr),
    .in_inc      (accept_c && s_axis_tlast),
    .cut_inc     (fwd_c && cut_c && !s_axis_tlast),
    .port        (eff_port_c),
    .out_inc     (tvalid_q && m_axis_tready && tlast_q),
    .pkt_in_cnt  (pkt_in_cnt),
    .pkt_cut_cnt (pkt_cut_cnt),
    .pkt_out_cnt (pkt_out_cnt)
  );

endmodule

// File: tb/tb_osnt_packet_cutter_mp.sv
// Randomized bench for osnt_packet_cutter_mp against a packet-level model of
// snap-length truncation, TUSER rewrite and statistics.
module tb_osnt_packet_cutter_mp;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned UW = 128;
  localparam int unsigned NP = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          axi_reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [NP-1:0]    cut_en;
  logic [NP*LW-1:0] snap_len;
  logic             stats_clr;
  logic [NP*CW-1:0] pkt_in_cnt, pkt_cut_cnt;
  logic [CW-1:0]    pkt_out_cnt;

  osnt_packet_cutter_mp #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(NP),
    .LEN_WIDTH(LW), .MIN_SNAP(64), .CNT_WIDTH(CW)
  ) dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .cut_en(cut_en), .snap_len(snap_len), .stats_clr(stats_clr),
    .pkt_in_cnt(pkt_in_cnt), .pkt_cut_cnt(pkt_cut_cnt), .pkt_out_cnt(pkt_out_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    vec_cnt = 0;
  int    err_cnt = 0;
  int    m_in[NP], m_cut[NP], m_out;
  int    sink_mode = 0;
  logic  force_rdy = 1'b0;
  bit    mon_en = 1'b0;
  int    cur_beats = 0, last_beats = 0;
  logic [KW-1:0] last_keep = '0;
  logic [15:0]   first_len = '0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] keep_of(input int n);
    if (n >= 32) return '1;
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  function automatic int snap_of(input int p);
    return int'(snap_len[p*LW +: LW]);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic zero_model();
    for (int p = 0; p < NP; p++) begin m_in[p] = 0; m_cut[p] = 0; end
    m_out = 0;
  endtask

  task automatic rand_cfg();
    cut_en = NP'($urandom);
    for (int p = 0; p < NP; p++) snap_len[p*LW +: LW] = LW'($urandom_range(0, 400));
  endtask

  // Output sink and beat checker
  initial begin
    logic          hold;
    beat_t         h, e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (sink_mode == 1)      m_axis_tready = ($urandom % 2) == 1;
      else if (sink_mode == 2) m_axis_tready = force_rdy;
      else                     m_axis_tready = 1'b1;
      #1;
      if (axi_reset || !mon_en) begin
        hold = 1'b0;
        cur_beats = 0;
      end else begin
        if (hold) begin
          check_eq("hold_valid", 256'(m_axis_tvalid), 256'(1));
          check_eq("hold_data", m_axis_tdata, h.d);
          check_eq("hold_keep", 256'(m_axis_tkeep), 256'(h.k));
          check_eq("hold_user", 256'(m_axis_tuser), 256'(h.u));
          check_eq("hold_last", 256'(m_axis_tlast), 256'(h.l));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("spurious_beat", 256'(exp_q.size()), 256'(1));
          end else begin
            e = exp_q.pop_front();
            check_eq("tdata", m_axis_tdata, e.d);
            check_eq("tkeep", 256'(m_axis_tkeep), 256'(e.k));
            check_eq("tuser", 256'(m_axis_tuser), 256'(e.u));
            check_eq("tlast", 256'(m_axis_tlast), 256'(e.l));
          end
          cur_beats++;
          if (cur_beats == 1) first_len = m_axis_tuser[15:0];
          if (m_axis_tlast) begin
            last_beats = cur_beats;
            last_keep  = m_axis_tkeep;
            cur_beats  = 0;
          end
        end else if (m_axis_tvalid) begin
          hold = 1'b1;
          h.d = m_axis_tdata; h.k = m_axis_tkeep; h.u = m_axis_tuser; h.l = m_axis_tlast;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [UW-1:0] u, input logic l, input bit scr);
    int n;
    @(negedge clk);
    if (scr) rand_cfg();
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u; s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axis_tready && n < 5000) begin @(negedge clk); #1; n++; end
    if (n >= 5000) check_eq("s_ready_timeout", 256'(n), 256'(0));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Model: resolve port, truncate to clamped snap, queue the expected beats
  task automatic send_pkt(input logic [7:0] src, input int len, input bit scr);
    int p, s, olen, nin, nout;
    logic [UW-1:0] u;
    logic [DW-1:0] d[$];
    beat_t e;
    p = 0;
    for (int i = NP - 1; i >= 0; i--) if (src[i]) p = i;
    s = snap_of(p);
    if (s < 64) s = 64;
    olen = (cut_en[p] && len > s) ? s : len;
    nin  = (len + 31) / 32;
    nout = (olen + 31) / 32;
    m_in[p]++;
    m_out++;
    if (cut_en[p] && nin > (s + 31) / 32) m_cut[p]++;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[23:16] = src;
    u[15:0]  = 16'(len);
    for (int b = 0; b < nin; b++) d.push_back(rand_data());
    for (int b = 0; b < nout; b++) begin
      e.d = d[b];
      e.k = keep_of((b == nout - 1) ? olen - b*32 : 32);
      e.u = u;
      if (b == 0 && cut_en[p]) e.u[15:0] = 16'(olen);
      e.l = (b == nout - 1);
      exp_q.push_back(e);
    end
    for (int b = 0; b < nin; b++)
      drive_beat(d[b], keep_of((b == nin - 1) ? len - b*32 : 32), u, b == nin - 1, scr && b == 1);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); #2; n++; end
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000);
    check_eq("drain_queue", 256'(exp_q.size()), 256'(0));
    check_eq("drain_tvalid", 256'(m_axis_tvalid), 256'(0));
  endtask

  task automatic check_stats(input string tag);
    for (int p = 0; p < NP; p++) begin
      check_eq({tag, "_in"},  256'(pkt_in_cnt[p*CW +: CW]),  256'(m_in[p]));
      check_eq({tag, "_cut"}, 256'(pkt_cut_cnt[p*CW +: CW]), 256'(m_cut[p]));
    end
    check_eq({tag, "_out"}, 256'(pkt_out_cnt), 256'(m_out));
  endtask

  task automatic clear_stats();
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    zero_model();
  endtask

  initial begin
    logic [7:0] src;
    int len, n;
    axi_reset = 1'b1; stats_clr = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cut_en = '0; snap_len = '0;
    zero_model();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_s_ready", 256'(s_axis_tready), 256'(0));
    check_eq("rst_m_valid", 256'(m_axis_tvalid), 256'(0));
    @(negedge clk);
    axi_reset = 1'b0;
    #1;
    check_eq("post_rst_s_ready", 256'(s_axis_tready), 256'(1));
    check_eq("post_rst_tdata", m_axis_tdata, 256'(0));
    check_eq("post_rst_tuser", 256'(m_axis_tuser), 256'(0));
    check_eq("post_rst_tkeep_tlast", 256'({m_axis_tkeep, m_axis_tlast}), 256'(0));
    check_stats("rst");
    mon_en = 1'b1;

    // Port 0, snap 64, 100-byte packet
    cut_en = 4'b0011;
    snap_len[0*LW +: LW] = 16'd64;
    snap_len[1*LW +: LW] = 16'd70;
    snap_len[3*LW +: LW] = 16'd10;
    send_pkt(8'h01, 100, 1'b0);
    drain();
    check_eq("t1_beats", 256'(last_beats), 256'(2));
    check_eq("t1_keep", 256'(last_keep), 256'(32'hFFFF_FFFF));
    check_eq("t1_len", 256'(first_len), 256'(64));
    check_eq("t1_cut0", 256'(pkt_cut_cnt[0 +: CW]), 256'(1));
    check_stats("t1");

    // Port 1, snap 70
    send_pkt(8'h02, 100, 1'b0);
    drain();
    check_eq("t2_beats", 256'(last_beats), 256'(3));
    check_eq("t2_keep", 256'(last_keep), 256'(32'h0000_003F));
    check_eq("t2_len", 256'(first_len), 256'(70));

    // Packets ending below and exactly at snap
    clear_stats();
    send_pkt(8'h01, 60, 1'b0);
    send_pkt(8'h01, 64, 1'b0);
    drain();
    check_eq("t3_beats", 256'(last_beats), 256'(2));
    check_eq("t3_len", 256'(first_len), 256'(64));
    check_eq("t3_cut0", 256'(pkt_cut_cnt[0 +: CW]), 256'(0));
    check_eq("t3_out", 256'(pkt_out_cnt), 256'(2));

    // Cut disabled on port 2; snap clamp on port 3
    send_pkt(8'h04, 1500, 1'b0);
    drain();
    check_eq("t4_beats", 256'(last_beats), 256'(47));
    check_eq("t4_len", 256'(first_len), 256'(1500));
    cut_en[3] = 1'b1;
    send_pkt(8'h08, 100, 1'b0);
    drain();
    check_eq("t4_clamp_beats", 256'(last_beats), 256'(2));
    check_eq("t4_clamp_len", 256'(first_len), 256'(64));
    check_stats("directed");

    // Random traffic with random backpressure and mid-packet config changes
    clear_stats();
    sink_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) rand_cfg();
      case ($urandom_range(0, 7))
        0:       src = 8'h00;
        1:       src = 8'($urandom);
        default: src = 8'(1 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 3) == 0) len = 32 * $urandom_range(1, 10);
      else                           len = $urandom_range(1, 400);
      send_pkt(src, len, 1'b1);
    end
    drain();
    check_stats("rand");

    // Clear coincides with an output tlast handshake
    sink_mode = 2;
    force_rdy = 1'b0;
    cut_en[0] = 1'b1;
    send_pkt(8'h01, 20, 1'b0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!m_axis_tvalid && n < 100);
    check_eq("t6_wait_valid", 256'(m_axis_tvalid), 256'(1));
    force_rdy = 1'b1;
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    #1;
    check_eq("t6_clr_out", 256'(pkt_out_cnt), 256'(0));
    zero_model();
    sink_mode = 0;
    drain();
    check_stats("t6_clr");

    // Reset in the middle of a packet
    mon_en = 1'b0;
    drive_beat(rand_data(), '1, {104'h0, 8'h02, 16'd128}, 1'b0, 1'b0);
    drive_beat(rand_data(), '1, {104'h0, 8'h02, 16'd128}, 1'b0, 1'b0);
    @(negedge clk);
    axi_reset = 1'b1; s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    axi_reset = 1'b0;
    exp_q.delete();
    zero_model();
    #1;
    check_eq("t6_rst_valid", 256'(m_axis_tvalid), 256'(0));
    check_eq("t6_rst_ready", 256'(s_axis_tready), 256'(1));
    mon_en = 1'b1;
    send_pkt(8'h02, 100, 1'b0);
    drain();
    check_eq("t6_rst_len", 256'(first_len), 256'(cut_en[1] ? ((snap_of(1) < 64 ? 64 : snap_of(1)) < 100 ? (snap_of(1) < 64 ? 64 : snap_of(1)) : 100) : 100));
    check_stats("t6_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
